// File: rtl/datamem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   arb_state_t : sequencer states (one transaction = IDLE -> ACCESS -> RESP)
//   mem_req_t   : captured request fields forwarded to the memory pins
package datamem_arb_pkg;

  localparam int unsigned ADDRESS_WIDTH = 32;
  localparam int unsigned DATA_WIDTH    = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                     we;
    logic                     byteop;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0]    wdata;
  } mem_req_t;

endpackage

// File: rtl/datamem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the data memory.
//   req0_* / req1_* : valid/ready request channel plus rvalid/rdata response
//   mem_*           : single-port memory pins (combinational read data)
// Modports: slave = arbiter side, master = requesters + memory side.
interface datamem_arbiter_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 32
);
  logic                     req0_valid, req0_we, req0_byte;
  logic [ADDRESS_WIDTH-1:0] req0_addr;
  logic [DATA_WIDTH-1:0]    req0_wdata;
  logic                     req0_ready, req0_rvalid;
  logic [DATA_WIDTH-1:0]    req0_rdata;

  logic                     req1_valid, req1_we, req1_byte;
  logic [ADDRESS_WIDTH-1:0] req1_addr;
  logic [DATA_WIDTH-1:0]    req1_wdata;
  logic                     req1_ready, req1_rvalid;
  logic [DATA_WIDTH-1:0]    req1_rdata;

  logic                     mem_we, mem_byteop;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic [DATA_WIDTH-1:0]    mem_rdata;

  modport slave (
    input  req0_valid, req0_we, req0_byte, req0_addr, req0_wdata,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_we, req1_byte, req1_addr, req1_wdata,
    output req1_ready, req1_rvalid, req1_rdata,
    output mem_we, mem_byteop, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output req0_valid, req0_we, req0_byte, req0_addr, req0_wdata,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_we, req1_byte, req1_addr, req1_wdata,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  mem_we, mem_byteop, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/datamem_arbiter_rr_arbiter2.sv
// Combinational two-way round-robin pick.
//   valid0/valid1 : request pending from requester 0/1
//   ptr           : requester favoured when both are valid
//   grant         : one-hot winner (all zero when nothing is valid)
module rr_arbiter2 (
  input  logic       valid0,
  input  logic       valid1,
  input  logic       ptr,
  output logic [1:0] grant
);
  always_comb begin
    grant    = '0;
    grant[0] = valid0 & (~valid1 | ~ptr);
    grant[1] = valid1 & (~valid0 |  ptr);
  end
endmodule

// File: rtl/datamem_arbiter.sv
// Round-robin sequencer sharing one single-port data memory between
// requester 0 (load/store unit) and requester 1 (debug/DMA loader).
// Each accepted request becomes exactly one memory cycle followed by a
// one-cycle rvalid pulse to its owner (accept T, access T+1, rvalid T+2).
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   bus        : requester channels and memory pins (slave modport)
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter int unsigned ADDRESS_WIDTH = datamem_arb_pkg::ADDRESS_WIDTH,
  parameter int unsigned DATA_WIDTH    = datamem_arb_pkg::DATA_WIDTH
) (
  input logic               clk,
  input logic               rst_n,
  datamem_arbiter_if.slave  bus
);

  arb_state_t            state_q, state_d;
  mem_req_t              req_q, req_d;
  logic                  owner_q, owner_d;
  logic                  ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] load_q, load_d;
  logic [DATA_WIDTH-1:0] rdata0_q, rdata0_d;
  logic [DATA_WIDTH-1:0] rdata1_q, rdata1_d;
  logic [1:0]            grant;
  logic                  accept;

  rr_arbiter2 u_pick (
    .valid0 (bus.req0_valid),
    .valid1 (bus.req1_valid),
    .ptr    (ptr_q),
    .grant  (grant)
  );

  assign accept = (state_q == IDLE) && (grant != 2'b00);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= '0;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b0;
      load_q   <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      req_q    <= req_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      load_q   <= load_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    req_d    = req_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    load_d   = load_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    if (accept) begin
      owner_d = grant[1];
      // Pointer always moves to the requester that did not win.
      ptr_d   = grant[0];
      if (grant[1]) req_d = '{bus.req1_we, bus.req1_byte, bus.req1_addr, bus.req1_wdata};
      else          req_d = '{bus.req0_we, bus.req0_byte, bus.req0_addr, bus.req0_wdata};
    end
    if (state_q == ACCESS) load_d = req_q.we ? '0 : bus.mem_rdata;
    if (state_q == RESP) begin
      if (owner_q) rdata1_d = load_q;
      else         rdata0_d = load_q;
    end
  end

  // Outputs; rdata is bypassed from load_q during RESP so it is valid with
  // rvalid yet the held value only changes at that requester's own rvalid.
  always_comb begin
    bus.req0_ready  = (state_q == IDLE) && grant[0];
    bus.req1_ready  = (state_q == IDLE) && grant[1];
    bus.req0_rvalid = (state_q == RESP) && !owner_q;
    bus.req1_rvalid = (state_q == RESP) &&  owner_q;
    bus.req0_rdata  = bus.req0_rvalid ? load_q : rdata0_q;
    bus.req1_rdata  = bus.req1_rvalid ? load_q : rdata1_q;
    bus.mem_we      = (state_q == ACCESS) && req_q.we;
    bus.mem_byteop  = req_q.byteop;
    bus.mem_addr    = req_q.addr;
    bus.mem_wdata   = req_q.wdata;
  end

endmodule

// File: tb/tb_datamem_arbiter.sv
module tb_datamem_arbiter;
  import datamem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  datamem_arbiter_if #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) bus ();

  datamem_arbiter #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Byte-addressed little-endian memory, 1 KiB, combinational read.
  logic [7:0] mem [0:1023] = '{default: 8'h00};
  logic [9:0] ma;
  assign ma = bus.mem_addr[9:0];
  always_comb begin
    if (bus.mem_byteop) bus.mem_rdata = {24'h0, mem[ma]};
    else bus.mem_rdata = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
  end
  always @(posedge clk) begin
    if (bus.mem_we) begin
      if (bus.mem_byteop) mem[ma] <= bus.mem_wdata[7:0];
      else begin
        mem[ma]          <= bus.mem_wdata[7:0];
        mem[ma + 10'd1]  <= bus.mem_wdata[15:8];
        mem[ma + 10'd2]  <= bus.mem_wdata[23:16];
        mem[ma + 10'd3]  <= bus.mem_wdata[31:24];
      end
    end
  end

  typedef struct {
    int unsigned id;
    logic        we;
    logic        bt;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  typedef struct {
    vec_t        v;
    int unsigned acc_cyc;
  } sb_t;

  vec_t        q0[$];
  vec_t        q1[$];
  sb_t         sb[$];
  int unsigned grant_log[$];
  vec_t        tbl[8];

  int unsigned vec_count = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;
  logic        ptr_m = 1'b0;
  logic [31:0] last_addr = '0, last_wdata = '0;
  logic        last_bt = 1'b0;
  logic [31:0] last_rd [2] = '{32'h0, 32'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    sb.delete(); q0.delete(); q1.delete();
    ptr_m = 1'b0;
    last_addr = '0; last_wdata = '0; last_bt = 1'b0;
    last_rd[0] = '0; last_rd[1] = '0;
  endtask

  task automatic check_zero();
    check("rst_ready0", bus.req0_ready, 0);
    check("rst_ready1", bus.req1_ready, 0);
    check("rst_rvalid0", bus.req0_rvalid, 0);
    check("rst_rvalid1", bus.req1_rvalid, 0);
    check("rst_rdata0", bus.req0_rdata, 0);
    check("rst_rdata1", bus.req1_rdata, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_byteop", bus.mem_byteop, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
  endtask

  // Per-cycle comparison against the expected transaction timeline.
  task automatic monitor();
    logic busy, acc_now, resp_now, win0, win1;
    int unsigned rid;
    cyc++;
    busy     = (sb.size() > 0);
    acc_now  = busy && (sb[0].acc_cyc + 1 == cyc);
    resp_now = busy && (sb[0].acc_cyc + 2 == cyc);
    if (acc_now) begin
      check("mem_we", bus.mem_we, sb[0].v.we);
      check("mem_addr", bus.mem_addr, sb[0].v.addr);
      check("mem_byteop", bus.mem_byteop, sb[0].v.bt);
      check("mem_wdata", bus.mem_wdata, sb[0].v.wdata);
      last_addr = sb[0].v.addr; last_bt = sb[0].v.bt; last_wdata = sb[0].v.wdata;
    end else begin
      check("idle_mem_we", bus.mem_we, 0);
      check("hold_mem_addr", bus.mem_addr, last_addr);
      check("hold_mem_byteop", bus.mem_byteop, last_bt);
      check("hold_mem_wdata", bus.mem_wdata, last_wdata);
    end
    rid = resp_now ? sb[0].v.id : 2;
    check("rvalid0", bus.req0_rvalid, rid == 0);
    check("rvalid1", bus.req1_rvalid, rid == 1);
    if (rid == 0) last_rd[0] = sb[0].v.exp_rdata;
    if (rid == 1) last_rd[1] = sb[0].v.exp_rdata;
    check("rdata0", bus.req0_rdata, last_rd[0]);
    check("rdata1", bus.req1_rdata, last_rd[1]);
    if (resp_now) void'(sb.pop_front());
    win0 = !busy && bus.req0_valid && (!bus.req1_valid || !ptr_m);
    win1 = !busy && bus.req1_valid && (!bus.req0_valid ||  ptr_m);
    check("ready0", bus.req0_ready, win0);
    check("ready1", bus.req1_ready, win1);
    if (win0 || win1) ptr_m = win0;
    if (bus.req0_valid && bus.req0_ready && q0.size() > 0) begin
      sb.push_back('{v: q0[0], acc_cyc: cyc});
      void'(q0.pop_front());
      grant_log.push_back(0);
    end
    if (bus.req1_valid && bus.req1_ready && q1.size() > 0) begin
      sb.push_back('{v: q1[0], acc_cyc: cyc});
      void'(q1.pop_front());
      grant_log.push_back(1);
    end
  endtask

  task automatic drive();
    bus.req0_valid = (q0.size() > 0);
    if (q0.size() > 0) begin
      bus.req0_we = q0[0].we; bus.req0_byte = q0[0].bt;
      bus.req0_addr = q0[0].addr; bus.req0_wdata = q0[0].wdata;
    end
    bus.req1_valid = (q1.size() > 0);
    if (q1.size() > 0) begin
      bus.req1_we = q1[0].we; bus.req1_byte = q1[0].bt;
      bus.req1_addr = q1[0].addr; bus.req1_wdata = q1[0].wdata;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) monitor();
    else check_zero();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run(input int unsigned max_cycles);
    int unsigned n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || sb.size() > 0) && n < max_cycles) begin
      tick();
      n++;
    end
    if (n >= max_cycles) begin
      vec_count++;
      miscompares++;
      $display("FAIL timeout: got %0d pending expected 0", q0.size() + q1.size() + sb.size());
      model_reset();
      drive();
    end
  endtask

  task automatic push(input vec_t v);
    if (v.id == 0) q0.push_back(v);
    else q1.push_back(v);
  endtask

  initial begin
    int unsigned n;
    bus.req0_valid = 0; bus.req0_we = 0; bus.req0_byte = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
    bus.req1_valid = 0; bus.req1_we = 0; bus.req1_byte = 0; bus.req1_addr = '0; bus.req1_wdata = '0;

    // Reset then idle
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();

    // Contention from reset: grant order 0,1,0,1
    push('{0, 1'b1, 1'b0, 32'h300, 32'h11223344, 32'h0});
    push('{0, 1'b0, 1'b0, 32'h304, 32'h0,        32'h55667788});
    push('{1, 1'b1, 1'b0, 32'h304, 32'h55667788, 32'h0});
    push('{1, 1'b0, 1'b0, 32'h300, 32'h0,        32'h11223344});
    run(40);
    for (int i = 0; i < 4; i++)
      check("grant_order", (grant_log.size() > i) ? grant_log[i] : 32'hFFFF, i % 2);
    grant_log.delete();

    // Sequential single-requester vectors
    tbl[0] = '{0, 1'b1, 1'b0, 32'h100, 32'hDEADBEEF, 32'h0};
    tbl[1] = '{1, 1'b0, 1'b0, 32'h100, 32'h0,        32'hDEADBEEF};
    tbl[2] = '{0, 1'b1, 1'b1, 32'h203, 32'hFFFFFFA5, 32'h0};
    tbl[3] = '{0, 1'b0, 1'b1, 32'h203, 32'h0,        32'h000000A5};
    tbl[4] = '{1, 1'b0, 1'b0, 32'h200, 32'h0,        32'hA5000000};
    tbl[5] = '{1, 1'b0, 1'b0, 32'h102, 32'h0,        32'h0000DEAD};
    tbl[6] = '{1, 1'b1, 1'b0, 32'h3FC, 32'hCAFEF00D, 32'h0};
    tbl[7] = '{0, 1'b0, 1'b0, 32'h3FC, 32'h12345678, 32'hCAFEF00D};
    for (int i = 0; i < 8; i++) begin
      push(tbl[i]);
      run(20);
      tick();
    end
    grant_log.delete();

    // Reset during the ACCESS cycle of a store
    push('{0, 1'b1, 1'b0, 32'h400, 32'h11111111, 32'h0});
    n = 0;
    while (sb.size() == 0 && n < 10) begin
      tick();
      n++;
    end
    check("abort_accepted", sb.size(), 1);
    check("abort_mem_we_before", bus.mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("abort_mem_we_now", bus.mem_we, 0);
    check("abort_rvalid0", bus.req0_rvalid, 0);
    model_reset();
    drive();
    grant_log.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    push('{0, 1'b0, 1'b0, 32'h400, 32'h0, 32'h0});
    push('{1, 1'b0, 1'b0, 32'h300, 32'h0, 32'h11223344});
    drive();
    run(30);
    check("post_reset_first", (grant_log.size() > 0) ? grant_log[0] : 32'hFFFF, 0);
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
